// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch-stage sequencing controller (next-PC select, redirect arbitration, fence.i, debug halt, icache replay)
// Ports: clk_i/rstn_i clock and async active-low reset; stall_i, redirect sources (commit > exe > decode),
// fence_i_*, debug_*, icache_ready_i/icache_replay_i in; next_pc_sel_o/pc_jump_o select and target,
// invalidate/retry/stall/fence_done/halted pulses and sticky retry_overflow_o out.
module fetch_ctrl #(
    parameter int ADDR_W        = 64,
    parameter int FENCE_TIMEOUT = 255,
    parameter int RETRY_MAX     = 7
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              stall_i,
    input  logic              debug_halt_req_i,
    input  logic              debug_resume_i,
    input  logic [ADDR_W-1:0] debug_pc_i,
    input  logic              commit_redirect_valid_i,
    input  logic [ADDR_W-1:0] commit_redirect_pc_i,
    input  logic              exe_mispred_valid_i,
    input  logic [ADDR_W-1:0] exe_mispred_pc_i,
    input  logic              decode_jump_valid_i,
    input  logic [ADDR_W-1:0] decode_jump_pc_i,
    input  logic              fence_i_valid_i,
    input  logic [ADDR_W-1:0] fence_i_next_pc_i,
    input  logic              icache_ready_i,
    input  logic              icache_replay_i,
    output logic [1:0]        next_pc_sel_o,
    output logic [ADDR_W-1:0] pc_jump_o,
    output logic              invalidate_icache_o,
    output logic              invalidate_buffer_o,
    output logic              retry_fetch_o,
    output logic              stall_debug_o,
    output logic              fence_done_o,
    output logic              debug_halted_o,
    output logic              retry_overflow_o
);
    typedef enum logic [1:0] {RUN, FENCE_INV, FENCE_WAIT, HALT} state_t;
    localparam logic [1:0] KEEP = 2'd0, NEXT = 2'd1, JUMP = 2'd2, DEBUG = 2'd3;
    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_fence_pc;
    logic [7:0]        r_to_cnt;
    logic [2:0]        r_retry_cnt;
    logic              r_overflow;
    logic              w_fence_take;
    assign retry_overflow_o = r_overflow;
    // Outputs are gated by rstn_i so an asserted reset forces them to idle values at once.
    always_comb begin
        w_state_nxt         = r_state;
        w_fence_take        = 1'b0;
        next_pc_sel_o       = KEEP;
        pc_jump_o           = '0;
        invalidate_icache_o = 1'b0;
        invalidate_buffer_o = 1'b0;
        retry_fetch_o       = 1'b0;
        stall_debug_o       = 1'b0;
        fence_done_o        = 1'b0;
        debug_halted_o      = 1'b0;
        if (rstn_i) begin
            case (r_state)
                RUN: begin
                    if (debug_halt_req_i) begin
                        w_state_nxt = HALT;
                    end else if (fence_i_valid_i) begin
                        // fence shares the commit slot with commit redirects and wins; lower sources drop
                        w_fence_take = 1'b1;
                        w_state_nxt  = FENCE_INV;
                    end else if (commit_redirect_valid_i || exe_mispred_valid_i || decode_jump_valid_i) begin
                        next_pc_sel_o       = JUMP;
                        invalidate_buffer_o = 1'b1;
                        pc_jump_o           = commit_redirect_valid_i ? commit_redirect_pc_i :
                                              exe_mispred_valid_i     ? exe_mispred_pc_i : decode_jump_pc_i;
                    end else begin
                        retry_fetch_o = icache_replay_i;
                        next_pc_sel_o = (stall_i || icache_replay_i) ? KEEP : NEXT;
                    end
                end
                FENCE_INV: begin
                    invalidate_icache_o = 1'b1;
                    invalidate_buffer_o = 1'b1;
                    stall_debug_o       = 1'b1;
                    w_state_nxt         = FENCE_WAIT;
                end
                FENCE_WAIT: begin
                    stall_debug_o = 1'b1;
                    if (icache_ready_i || r_to_cnt == 8'(FENCE_TIMEOUT)) begin
                        next_pc_sel_o = JUMP;
                        pc_jump_o     = r_fence_pc;
                        fence_done_o  = 1'b1;
                        w_state_nxt   = RUN;
                    end
                end
                HALT: begin
                    stall_debug_o  = 1'b1;
                    debug_halted_o = 1'b1;
                    if (debug_resume_i) begin
                        next_pc_sel_o       = DEBUG;
                        pc_jump_o           = debug_pc_i;
                        invalidate_buffer_o = 1'b1;
                        w_state_nxt         = RUN;
                    end
                end
            endcase
        end
    end
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state     <= RUN;
            r_fence_pc  <= '0;
            r_to_cnt    <= '0;
            r_retry_cnt <= '0;
            r_overflow  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_to_cnt <= (r_state == FENCE_WAIT) ? r_to_cnt + 8'd1 : 8'd0;
            if (w_fence_take)
                r_fence_pc <= fence_i_next_pc_i;
            // counter saturates at RETRY_MAX; a further replay only raises the sticky flag
            if (next_pc_sel_o != KEEP)
                r_retry_cnt <= '0;
            else if (retry_fetch_o) begin
                if (r_retry_cnt == 3'(RETRY_MAX))
                    r_overflow <= 1'b1;
                else
                    r_retry_cnt <= r_retry_cnt + 3'd1;
            end
        end
    end
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed and randomized checks of fetch_ctrl against a behavioural model
module tb_fetch_ctrl;
    localparam int AW = 64;
    logic          clk_i = 1'b0, rstn_i = 1'b0;
    logic          stall_i, debug_halt_req_i, debug_resume_i;
    logic [AW-1:0] debug_pc_i, commit_redirect_pc_i, exe_mispred_pc_i, decode_jump_pc_i, fence_i_next_pc_i;
    logic          commit_redirect_valid_i, exe_mispred_valid_i, decode_jump_valid_i;
    logic          fence_i_valid_i, icache_ready_i, icache_replay_i;
    logic [1:0]    next_pc_sel_o;
    logic [AW-1:0] pc_jump_o;
    logic          invalidate_icache_o, invalidate_buffer_o, retry_fetch_o, stall_debug_o;
    logic          fence_done_o, debug_halted_o, retry_overflow_o;
    fetch_ctrl #(.ADDR_W(AW), .FENCE_TIMEOUT(255), .RETRY_MAX(7)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .stall_i(stall_i),
        .debug_halt_req_i(debug_halt_req_i), .debug_resume_i(debug_resume_i), .debug_pc_i(debug_pc_i),
        .commit_redirect_valid_i(commit_redirect_valid_i), .commit_redirect_pc_i(commit_redirect_pc_i),
        .exe_mispred_valid_i(exe_mispred_valid_i), .exe_mispred_pc_i(exe_mispred_pc_i),
        .decode_jump_valid_i(decode_jump_valid_i), .decode_jump_pc_i(decode_jump_pc_i),
        .fence_i_valid_i(fence_i_valid_i), .fence_i_next_pc_i(fence_i_next_pc_i),
        .icache_ready_i(icache_ready_i), .icache_replay_i(icache_replay_i),
        .next_pc_sel_o(next_pc_sel_o), .pc_jump_o(pc_jump_o),
        .invalidate_icache_o(invalidate_icache_o), .invalidate_buffer_o(invalidate_buffer_o),
        .retry_fetch_o(retry_fetch_o), .stall_debug_o(stall_debug_o), .fence_done_o(fence_done_o),
        .debug_halted_o(debug_halted_o), .retry_overflow_o(retry_overflow_o)
    );
    always #5 clk_i = ~clk_i;
    int errors = 0, checks = 0;
    bit          m_halted, m_inv, m_wait, m_ovf, n_halted, n_inv, n_wait, n_ovf;
    int          m_wn, m_rc, n_wn, n_rc;
    logic [AW-1:0] m_fpc, n_fpc, e_pc;
    logic [1:0]  e_sel;
    bit          e_ib, e_ic, e_rt, e_sd, e_fd;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask
    task automatic clr_in();
        stall_i = 0; debug_halt_req_i = 0; debug_resume_i = 0; debug_pc_i = '0;
        commit_redirect_valid_i = 0; commit_redirect_pc_i = '0; exe_mispred_valid_i = 0; exe_mispred_pc_i = '0;
        decode_jump_valid_i = 0; decode_jump_pc_i = '0; fence_i_valid_i = 0; fence_i_next_pc_i = '0;
        icache_ready_i = 0; icache_replay_i = 0;
    endtask
    task automatic model_reset();
        m_halted = 0; m_inv = 0; m_wait = 0; m_ovf = 0; m_wn = 0; m_rc = 0; m_fpc = '0;
    endtask
    // evaluate the model for the current inputs and compare every output
    task automatic settle();
        #1;
        n_halted = m_halted; n_inv = 0; n_wait = m_wait; n_wn = m_wn; n_fpc = m_fpc; n_rc = m_rc; n_ovf = m_ovf;
        e_sel = 2'd1; e_pc = '0; e_ib = 0; e_ic = 0; e_rt = 0; e_sd = 0; e_fd = 0;
        if (m_halted) begin
            e_sd = 1; e_sel = 2'd0;
            if (debug_resume_i) begin e_sel = 2'd3; e_pc = debug_pc_i; e_ib = 1; n_halted = 0; end
        end else if (m_inv) begin
            e_ic = 1; e_ib = 1; e_sd = 1; e_sel = 2'd0; n_wait = 1; n_wn = 0;
        end else if (m_wait) begin
            e_sd = 1; e_sel = 2'd0;
            if (icache_ready_i || m_wn == 255) begin e_sel = 2'd2; e_pc = m_fpc; e_fd = 1; n_wait = 0; end
            else n_wn = m_wn + 1;
        end else if (debug_halt_req_i) begin
            e_sel = 2'd0; n_halted = 1;
        end else if (fence_i_valid_i) begin
            e_sel = 2'd0; n_fpc = fence_i_next_pc_i; n_inv = 1;
        end else if (commit_redirect_valid_i) begin
            e_sel = 2'd2; e_pc = commit_redirect_pc_i; e_ib = 1;
        end else if (exe_mispred_valid_i) begin
            e_sel = 2'd2; e_pc = exe_mispred_pc_i; e_ib = 1;
        end else if (decode_jump_valid_i) begin
            e_sel = 2'd2; e_pc = decode_jump_pc_i; e_ib = 1;
        end else begin
            e_rt = icache_replay_i; e_sel = (stall_i || icache_replay_i) ? 2'd0 : 2'd1;
        end
        if (e_sel != 0) n_rc = 0;
        else if (e_rt) begin
            if (m_rc >= 7) n_ovf = 1; else n_rc = m_rc + 1;
        end
        chk("sel", next_pc_sel_o, e_sel);
        chk("pc_jump", pc_jump_o, e_pc);
        chk("inv_icache", invalidate_icache_o, e_ic);
        chk("inv_buffer", invalidate_buffer_o, e_ib);
        chk("retry", retry_fetch_o, e_rt);
        chk("stall_debug", stall_debug_o, e_sd);
        chk("fence_done", fence_done_o, e_fd);
        chk("halted", debug_halted_o, m_halted);
        chk("overflow", retry_overflow_o, m_ovf);
    endtask
    task automatic tick();
        m_halted = n_halted; m_inv = n_inv; m_wait = n_wait; m_wn = n_wn; m_fpc = n_fpc; m_rc = n_rc; m_ovf = n_ovf;
        @(posedge clk_i); #1;
    endtask
    task automatic step();
        settle(); tick();
    endtask
    task automatic do_reset();
        commit_redirect_valid_i = 1; icache_replay_i = 1;
        rstn_i = 0; #1;
        chk("rst_sel", next_pc_sel_o, 0);
        chk("rst_pc", pc_jump_o, 0);
        chk("rst_ib", invalidate_buffer_o, 0);
        chk("rst_ic", invalidate_icache_o, 0);
        chk("rst_retry", retry_fetch_o, 0);
        chk("rst_sd", stall_debug_o, 0);
        chk("rst_fd", fence_done_o, 0);
        chk("rst_halted", debug_halted_o, 0);
        chk("rst_ovf", retry_overflow_o, 0);
        clr_in(); model_reset();
        @(posedge clk_i); #1;
        rstn_i = 1;
    endtask
    initial begin
        int k;
        clr_in(); model_reset();
        #2; do_reset();
        for (int i = 0; i < 3; i++) begin settle(); chk("idle_sel", next_pc_sel_o, 1); tick(); end
        stall_i = 1; settle(); chk("stall_sel", next_pc_sel_o, 0); tick(); stall_i = 0;
        commit_redirect_valid_i = 1; commit_redirect_pc_i = 64'h8000_0100;
        exe_mispred_valid_i = 1; exe_mispred_pc_i = 64'h8000_0200;
        decode_jump_valid_i = 1; decode_jump_pc_i = 64'h8000_0300;
        settle(); chk("prio_sel", next_pc_sel_o, 2); chk("prio_pc", pc_jump_o, 64'h8000_0100);
        chk("prio_ib", invalidate_buffer_o, 1); tick();
        commit_redirect_valid_i = 0; decode_jump_valid_i = 0;
        settle(); chk("exe_pc", pc_jump_o, 64'h8000_0200); tick();
        clr_in();
        fence_i_valid_i = 1; fence_i_next_pc_i = 64'h8000_0044; step(); clr_in();
        settle(); chk("finv_ic", invalidate_icache_o, 1); chk("finv_ib", invalidate_buffer_o, 1); tick();
        for (int i = 0; i < 5; i++) begin
            settle(); chk("fwait_sel", next_pc_sel_o, 0); chk("fwait_sd", stall_debug_o, 1); tick();
        end
        icache_ready_i = 1;
        settle(); chk("fdone_sel", next_pc_sel_o, 2); chk("fdone_pc", pc_jump_o, 64'h8000_0044);
        chk("fdone_pulse", fence_done_o, 1); tick(); clr_in();
        fence_i_valid_i = 1; fence_i_next_pc_i = 64'h8000_0088; step(); clr_in(); step();
        for (k = 0; k < 300; k++) begin settle(); if (fence_done_o) break; tick(); end
        chk("fence_timeout_len", k, 255); chk("ftmo_pc", pc_jump_o, 64'h8000_0088); tick();
        fence_i_valid_i = 1; fence_i_next_pc_i = 64'h8000_00c0; step(); clr_in(); step();
        debug_halt_req_i = 1; step(); step();
        icache_ready_i = 1; settle(); chk("defer_fd", fence_done_o, 1); chk("defer_halted", debug_halted_o, 0); tick();
        icache_ready_i = 0; settle(); chk("halt_entry_sel", next_pc_sel_o, 0); tick();
        settle(); chk("halted_on", debug_halted_o, 1); tick();
        debug_halt_req_i = 0; debug_resume_i = 1; debug_pc_i = 64'h8000_1000;
        settle(); chk("resume_sel", next_pc_sel_o, 3); chk("resume_pc", pc_jump_o, 64'h8000_1000); tick();
        clr_in(); settle(); chk("halted_off", debug_halted_o, 0); tick();
        icache_replay_i = 1;
        for (int i = 0; i < 8; i++) begin
            settle(); chk("replay_rt", retry_fetch_o, 1); chk("replay_sel", next_pc_sel_o, 0);
            chk("replay_ovf_pre", retry_overflow_o, 0); tick();
        end
        icache_replay_i = 0; exe_mispred_valid_i = 1; exe_mispred_pc_i = 64'h8000_0400;
        settle(); chk("ovf_set", retry_overflow_o, 1); chk("ovf_exe_sel", next_pc_sel_o, 2); tick();
        clr_in(); settle(); chk("ovf_sticky", retry_overflow_o, 1); tick();
        fence_i_valid_i = 1; fence_i_next_pc_i = 64'h8000_0500; step(); clr_in(); step(); step();
        settle(); chk("pre_rst_sd", stall_debug_o, 1);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            settle(); chk("post_rst_sel", next_pc_sel_o, 1); chk("post_rst_fd", fence_done_o, 0); tick();
        end
        for (int i = 0; i < 3000; i++) begin
            stall_i = ($urandom % 4) == 0;
            if (($urandom % 30) == 0) debug_halt_req_i = ~debug_halt_req_i;
            debug_resume_i = ($urandom % 8) == 0; debug_pc_i = {$urandom, $urandom};
            commit_redirect_valid_i = ($urandom % 12) == 0; commit_redirect_pc_i = {$urandom, $urandom};
            exe_mispred_valid_i = ($urandom % 8) == 0; exe_mispred_pc_i = {$urandom, $urandom};
            decode_jump_valid_i = ($urandom % 6) == 0; decode_jump_pc_i = {$urandom, $urandom};
            fence_i_valid_i = ($urandom % 30) == 0; fence_i_next_pc_i = {$urandom, $urandom};
            icache_ready_i = ($urandom % 4) == 0;
            icache_replay_i = ($urandom % 3) == 0;
            step();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Sequencing controller for fetch stage 1.
- Each cycle it decides the next-PC select (KEEP / BP_OR_PC_4 / JUMP / DEBUG) and the redirect target for the PC register, arbitrating redirect sources by priority.
- Runs a fence.i invalidation sequence and debug halt/resume.
- Generates icache replay (retry) requests.
- Sits between the control unit, backend redirect sources and the fetch stage; it is the only driver of the fetch-stage cu_if next_pc select, pc_jump, invalidate and retry inputs.

Parameters:
- ADDR_W, 64, PC / redirect address width.
- FENCE_TIMEOUT, 255, max cycles waiting for icache_ready_i after invalidate; range 1..255.
- RETRY_MAX, 7, consecutive replays of one PC before retry_overflow_o; range 1..7.

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  async active-low reset
- stall_i  in  1  backend stall; fetch must hold PC
- debug_halt_req_i  in  1  debug module halt request (level)
- debug_resume_i  in  1  resume pulse
- debug_pc_i  in  ADDR_W  resume PC (dpc)
- commit_redirect_valid_i  in  1  exception/xret redirect from commit
- commit_redirect_pc_i  in  ADDR_W  its target
- exe_mispred_valid_i  in  1  branch mispredict from exe
- exe_mispred_pc_i  in  ADDR_W  corrected target
- decode_jump_valid_i  in  1  JAL redirect from decode
- decode_jump_pc_i  in  ADDR_W  its target
- fence_i_valid_i  in  1  fence.i reached commit (pulse)
- fence_i_next_pc_i  in  ADDR_W  PC after the fence
- icache_ready_i  in  1  icache idle/ready after invalidate
- icache_replay_i  in  1  icache dropped current request, refetch same PC
- next_pc_sel_o  out  2  0=KEEP_PC, 1=BP_OR_PC_4, 2=JUMP, 3=DEBUG
- pc_jump_o  out  ADDR_W  redirect target
- invalidate_icache_o  out  1  icache invalidate pulse
- invalidate_buffer_o  out  1  fetch buffer invalidate pulse
- retry_fetch_o  out  1  replay request to icache
- stall_debug_o  out  1  fetch gated for debug/fence
- fence_done_o  out  1  one-cycle pulse at fence completion
- debug_halted_o  out  1  core halted
- retry_overflow_o  out  1  sticky; replay count exceeded RETRY_MAX

Behaviour:
- FSM states: RUN, FENCE_INV, FENCE_WAIT, HALT.
- Reset values: state=RUN, next_pc_sel_o=KEEP, pc_jump_o=0, all pulses/flags 0, counters 0.
- next_pc_sel_o and pc_jump_o are combinational from the current state and inputs, so a redirect reaches the PC register on the next edge (1-cycle redirect latency).
- RUN redirect priority, highest first: debug_halt_req_i, then commit, then exe, then decode.
  - Winner among commit/exe/decode: sel=JUMP, pc_jump_o=winner's PC. Lower sources are ignored that cycle; nothing is queued.
  - Redirects override stall_i, because the backend flushes on redirect.
  - No redirect: stall_i or icache_replay_i gives KEEP; otherwise BP_OR_PC_4.
- Any redirect asserts invalidate_buffer_o the same cycle.
- icache_replay_i in RUN with no redirect:
  - retry_fetch_o=1 same cycle; retry counter increments.
  - Counter clears on any cycle with sel≠KEEP.
  - When the counter reaches RETRY_MAX and another replay arrives, retry_overflow_o sets. It is sticky until reset. The replay is still issued.
- fence.i sequence:
  - fence_i_valid_i in RUN (no debug halt): latch fence_i_next_pc_i; go to FENCE_INV.
  - Simultaneous commit redirect: the fence wins (same commit slot; commit must not assert both).
  - Lower-priority redirects that cycle are dropped.
- FENCE_INV, 1 cycle: invalidate_icache_o=1, invalidate_buffer_o=1, stall_debug_o=1, sel=KEEP. Go to FENCE_WAIT; timeout counter cleared.
- FENCE_WAIT: stall_debug_o=1, sel=KEEP; timeout counter increments each cycle. Exit when icache_ready_i=1 or counter==FENCE_TIMEOUT. On exit:
  - sel=JUMP, pc_jump_o=latched PC
  - fence_done_o=1
  - go to RUN
  - A debug halt request in FENCE_WAIT is deferred until the fence completes.
- HALT:
  - Entry: on debug_halt_req_i from RUN, sel=KEEP on the entry cycle.
  - In HALT: stall_debug_o=1, debug_halted_o=1, sel=KEEP; all redirects and icache_replay_i ignored.
  - debug_resume_i: sel=DEBUG, pc_jump_o=debug_pc_i, invalidate_buffer_o=1, go to RUN. debug_halted_o drops the next cycle.
  - A debug resume while debug_halt_req_i is still high re-enters HALT on the following cycle.
- Async reset mid-sequence (any state) returns to RUN immediately. A pending fence is discarded and no fence_done_o is issued.

Test Plan:
- Reset, no stimulus → sel=1 every cycle; all pulses 0. stall_i=1 → sel=0.
- Same cycle: commit PC 0x8000_0100, exe 0x8000_0200, decode 0x8000_0300 → sel=2, pc_jump_o=0x8000_0100, invalidate_buffer_o=1. Next cycle with exe only → pc_jump_o=0x8000_0200.
- fence.i with next PC 0x8000_0044, icache_ready_i low for 5 cycles:
  - 1 cycle with both invalidates
  - 5 cycles KEEP with stall_debug_o=1
  - then sel=2 to 0x8000_0044 with fence_done_o
  - Repeat with icache_ready_i stuck low → exit after FENCE_TIMEOUT=255 cycles.
- Debug halt request during FENCE_WAIT → fence completes first, then HALT. Resume with debug_pc_i=0x8000_1000 → sel=3, pc_jump_o=0x8000_1000, debug_halted_o low the next cycle.
- 8 consecutive icache_replay_i → retry_fetch_o each cycle, sel=0, retry_overflow_o set on the 8th and stays set; an exe redirect clears the counter but not the flag.
- rstn_i low during FENCE_WAIT → all outputs at reset values asynchronously. After release, sel=1 and no fence_done_o.
